// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze geometry, direction codes and wall map
package maze_pkg;

    localparam int TILE_SHIFT = 4;
    localparam int MAZE_ROWS  = 30;
    localparam int MAZE_COLS  = 40;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [MAZE_COLS-1:0] ROW_WALL = 40'hFF_FFFF_FFFF;
    localparam logic [MAZE_COLS-1:0] ROW_OPEN = 40'h80_0000_0001;
    localparam logic [MAZE_COLS-1:0] ROW_BARS = 40'hBC_F3CF_3CF1;
    localparam logic [MAZE_COLS-1:0] ROW_STEP = 40'h87_0E1C_3871;

    // Index [row][col]; bit col of each row word is that tile's wall flag.
    localparam logic [MAZE_COLS-1:0] MAZE_MAP [MAZE_ROWS] = '{
        ROW_WALL, ROW_OPEN, ROW_OPEN, ROW_BARS, ROW_OPEN, ROW_STEP,
        ROW_OPEN, ROW_BARS, ROW_OPEN, ROW_STEP, ROW_OPEN, ROW_BARS,
        ROW_OPEN, ROW_STEP, ROW_OPEN, ROW_BARS, ROW_OPEN, ROW_STEP,
        ROW_OPEN, ROW_BARS, ROW_OPEN, ROW_STEP, ROW_OPEN, ROW_BARS,
        ROW_OPEN, ROW_STEP, ROW_OPEN, ROW_BARS, ROW_OPEN, ROW_WALL
    };

    // Border walls and the guaranteed corridors/ghost home override the map.
    function automatic logic maze_wall(input logic [6:0] row, input logic [6:0] col);
        logic wall;
        if (row >= 7'(MAZE_ROWS) || col >= 7'(MAZE_COLS))
            wall = 1'b1;
        else if (row == 7'd0 || row == 7'(MAZE_ROWS-1) || col == 7'd0 || col == 7'(MAZE_COLS-1))
            wall = 1'b1;
        else if (row == 7'd1 || col == 7'd1)
            wall = 1'b0;
        else if ((row == 7'd8 || row == 7'd9) && (col == 7'd12 || col == 7'd13))
            wall = 1'b0;
        else
            wall = MAZE_MAP[row[4:0]][col[5:0]];
        return wall;
    endfunction

endpackage

// File: rtl/maze_tile_rom.sv
// rtl/maze_tile_rom.sv - combinational tile row/col to wall-bit lookup
module maze_tile_rom
    import maze_pkg::*;
(
    input  logic [6:0] row,
    input  logic [6:0] col,
    output logic       wall
);

    assign wall = maze_wall(row, col);

endmodule

// File: rtl/maze_collision_checker.sv
// rtl/maze_collision_checker.sv - registered one-pixel step check against maze walls and field bounds
module maze_collision_checker
    import maze_pkg::*;
#(
    parameter int TILE_SHIFT  = 4,
    parameter int SPRITE_SIZE = 16,
    parameter int FIELD_W     = 640,
    parameter int FIELD_H     = 480
) (
    input  logic       clkdiv,
    input  logic       rst,
    input  logic [9:0] pos_x,
    input  logic [8:0] pos_y,
    input  logic [1:0] dir,
    output logic       result
);

    logic [10:0] tx;
    logic [10:0] ty;
    logic [10:0] x_r;
    logic [10:0] y_b;
    logic        underflow;
    logic        in_bounds;
    logic [10:0] pa_x;
    logic [10:0] pa_y;
    logic [10:0] pb_x;
    logic [10:0] pb_y;
    logic        wall_a;
    logic        wall_b;
    logic        step_ok;

    always_comb begin
        tx        = {1'b0, pos_x};
        ty        = {2'b00, pos_y};
        underflow = 1'b0;
        case (dir)
            DIR_UP: begin
                underflow = (pos_y == '0);
                ty        = {2'b00, pos_y} - 11'd1;
            end
            DIR_DOWN:  ty = {2'b00, pos_y} + 11'd1;
            DIR_LEFT: begin
                underflow = (pos_x == '0);
                tx        = {1'b0, pos_x} - 11'd1;
            end
            default:   tx = {1'b0, pos_x} + 11'd1;
        endcase
    end

    assign x_r       = tx + 11'(SPRITE_SIZE - 1);
    assign y_b       = ty + 11'(SPRITE_SIZE - 1);
    assign in_bounds = (x_r < 11'(FIELD_W)) && (y_b < 11'(FIELD_H));

    // Two probes on the leading edge of the target box; default is the up edge.
    always_comb begin
        pa_x = tx;
        pa_y = ty;
        pb_x = x_r;
        pb_y = ty;
        case (dir)
            DIR_DOWN: begin
                pa_y = y_b;
                pb_y = y_b;
            end
            DIR_LEFT: begin
                pb_x = tx;
                pb_y = y_b;
            end
            DIR_RIGHT: begin
                pa_x = x_r;
                pb_y = y_b;
            end
            default: ;
        endcase
    end

    maze_tile_rom u_rom_a (
        .row  (7'(pa_y >> TILE_SHIFT)),
        .col  (7'(pa_x >> TILE_SHIFT)),
        .wall (wall_a)
    );

    maze_tile_rom u_rom_b (
        .row  (7'(pb_y >> TILE_SHIFT)),
        .col  (7'(pb_x >> TILE_SHIFT)),
        .wall (wall_b)
    );

    assign step_ok = in_bounds && !underflow && !wall_a && !wall_b;

    always_ff @(posedge clkdiv) begin
        if (!rst)
            result <= 1'b0;
        else
            result <= step_ok;
    end

endmodule

// File: tb/tb_maze_collision_checker.sv
// tb/tb_maze_collision_checker.sv - randomized self-checking bench for maze_collision_checker
module tb_maze_collision_checker;
    import maze_pkg::*;

    logic       clkdiv = 1'b0;
    logic       rst    = 1'b0;
    logic [9:0] pos_x  = '0;
    logic [8:0] pos_y  = '0;
    logic [1:0] dir    = '0;
    logic       result;

    int errors = 0;
    int checks = 0;

    maze_collision_checker dut (
        .clkdiv (clkdiv),
        .rst    (rst),
        .pos_x  (pos_x),
        .pos_y  (pos_y),
        .dir    (dir),
        .result (result)
    );

    always #5 clkdiv = ~clkdiv;

    function automatic bit tile_is_wall(int r, int c);
        if (r < 0 || r > 29 || c < 0 || c > 39) return 1'b1;
        if (r == 0 || r == 29 || c == 0 || c == 39) return 1'b1;
        if (r == 1 || c == 1) return 1'b0;
        if ((r == 8 || r == 9) && (c == 12 || c == 13)) return 1'b0;
        return maze_pkg::MAZE_MAP[r][c];
    endfunction

    function automatic bit pixel_free(int px, int py);
        return !tile_is_wall(py / 16, px / 16);
    endfunction

    function automatic bit model_step(int x, int y, int d);
        int tx = x;
        int ty = y;
        int l, r, t, b;
        if (d == 0) ty = y - 1;
        else if (d == 1) ty = y + 1;
        else if (d == 2) tx = x - 1;
        else tx = x + 1;
        if (tx < 0 || ty < 0) return 1'b0;
        if (tx + 15 >= 640 || ty + 15 >= 480) return 1'b0;
        l = tx; r = tx + 15; t = ty; b = ty + 15;
        if (d == 0) return pixel_free(l, t) && pixel_free(r, t);
        if (d == 1) return pixel_free(l, b) && pixel_free(r, b);
        if (d == 2) return pixel_free(l, t) && pixel_free(l, b);
        return pixel_free(r, t) && pixel_free(r, b);
    endfunction

    task automatic drive(input int x, input int y, input int d);
        @(negedge clkdiv);
        pos_x = 10'(x);
        pos_y = 9'(y);
        dir   = 2'(d);
        @(posedge clkdiv);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(16, 16, 0);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL reset_edge1: result=%0b expected=0", result);
        end
        drive(16, 16, 3);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL reset_edge2_free_step: result=%0b expected=0", result);
        end
        rst = 1'b1;
        drive(16, 16, 3);
        checks++;
        if (result !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: result=%0b expected=1", result);
        end
    endtask

    task automatic test_top_wall;
        drive(16, 16, 0);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL top_wall: result=%0b expected=0", result);
        end
    endtask

    task automatic test_open_row;
        bit exp;
        drive(16, 16, 3);
        checks++;
        if (result !== 1'b1) begin
            errors++;
            $display("FAIL open_row_start: result=%0b expected=1", result);
        end
        for (int x = 17; x <= 608; x++) begin
            drive(x, 16, 3);
            exp = (x < 608);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL open_row_sweep: x=%0d result=%0b expected=%0b", x, result, exp);
            end
        end
    endtask

    task automatic test_left;
        drive(0, 16, 2);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL left_underflow: result=%0b expected=0", result);
        end
        drive(16, 16, 2);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL left_wall: result=%0b expected=0", result);
        end
        drive(0, 0, 0);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL up_underflow: result=%0b expected=0", result);
        end
    endtask

    task automatic test_down;
        drive(16, 16, 1);
        checks++;
        if (result !== 1'b1) begin
            errors++;
            $display("FAIL down_corridor: result=%0b expected=1", result);
        end
        drive(16, 447, 1);
        checks++;
        if (result !== 1'b1) begin
            errors++;
            $display("FAIL down_last_free: result=%0b expected=1", result);
        end
        drive(16, 448, 1);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL down_bottom_wall: result=%0b expected=0", result);
        end
    endtask

    task automatic test_bounds;
        drive(630, 16, 3);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL bounds_right: result=%0b expected=0", result);
        end
        drive(16, 470, 1);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL bounds_bottom: result=%0b expected=0", result);
        end
        drive(200, 146, 3);
        checks++;
        if (result !== model_step(200, 146, 3)) begin
            errors++;
            $display("FAIL ghost_home: result=%0b expected=%0b", result, model_step(200, 146, 3));
        end
    endtask

    task automatic test_dir_tracking;
        int  dirs[8] = '{3, 1, 0, 2, 3, 0, 1, 3};
        bit  prev;
        bit  exp;
        drive(16, 16, 3);
        prev = model_step(16, 16, 3);
        for (int i = 0; i < 8; i++) begin
            @(negedge clkdiv);
            pos_x = 10'(16 + i);
            dir   = 2'(dirs[i]);
            #1;
            checks++;
            if (result !== prev) begin
                errors++;
                $display("FAIL track_hold: step=%0d result=%0b expected=%0b", i, result, prev);
            end
            @(posedge clkdiv);
            #1;
            exp = model_step(16 + i, 16, dirs[i]);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL track_update: step=%0d result=%0b expected=%0b", i, result, exp);
            end
            prev = exp;
        end
    endtask

    task automatic test_mid_reset;
        drive(16, 16, 3);
        rst = 1'b0;
        drive(16, 16, 3);
        checks++;
        if (result !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: result=%0b expected=0", result);
        end
        rst = 1'b1;
        drive(16, 16, 3);
        checks++;
        if (result !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_resume: result=%0b expected=1", result);
        end
    endtask

    task automatic test_back_to_back_random;
        int x, y, d;
        bit exp;
        for (int i = 0; i < 400; i++) begin
            x = (i % 4 == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 630);
            y = (i % 4 == 0) ? $urandom_range(0, 511) : $urandom_range(0, 470);
            d = $urandom_range(0, 3);
            drive(x, y, d);
            exp = model_step(x, y, d);
            checks++;
            if (result !== exp) begin
                errors++;
                $display("FAIL random: x=%0d y=%0d dir=%0d result=%0b expected=%0b", x, y, d, result, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_top_wall();
        test_open_row();
        test_left();
        test_down();
        test_bounds();
        test_dir_tracking();
        test_mid_reset();
        test_back_to_back_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/maze_collision_checker.md
Name: maze_collision_checker

Overview:
- Checks whether a 16x16 sprite (Pac-Man or a ghost) can move one pixel in its current direction without entering a maze wall tile or leaving the playfield.
- Sits between each sprite's position/direction registers and its movement logic.
- Output 1 means the step is allowed, and the mover advances. Output 0 means blocked, and the mover chooses a new direction.

Parameters:
- TILE_SHIFT, 4, log2 of tile size in pixels (16 px tiles).
- SPRITE_SIZE, 16, sprite width and height in pixels.
- FIELD_W, 640, playfield width in pixels.
- FIELD_H, 480, playfield height in pixels.

Ports:
- clkdiv  input  1  clock, rising-edge (a divided system clock).
- rst  input  1  synchronous, active-low reset.
- pos_x  input  10  sprite top-left X, in pixels.
- pos_y  input  9  sprite top-left Y, in pixels.
- dir  input  2  move direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
- result  output  1  registered; 1 = step is free, 0 = blocked.

Behaviour:
- Reset: on a rising clkdiv edge with rst=0, result <= 0. Reset has priority over evaluation.
- Latency: one cycle.
  - Inputs are sampled at edge N; result reflects them after edge N.
  - There is no handshake; evaluation runs every cycle.
- Target position: tx/ty = pos ± 1 per dir, computed 11 bits wide (signed headroom).
  - Underflow (pos_x=0 going left, pos_y=0 going up) -> blocked.
- Bounds: blocked if tx+SPRITE_SIZE-1 >= FIELD_W, or ty+SPRITE_SIZE-1 >= FIELD_H.
- Leading-edge probe points, using the target box (tx..tx+15, ty..ty+15):
  - up: (tx,ty) and (tx+15,ty)
  - down: (tx,ty+15) and (tx+15,ty+15)
  - left: (tx,ty) and (tx,ty+15)
  - right: (tx+15,ty) and (tx+15,ty+15)
- Tile lookup: col = px>>TILE_SHIFT, row = py>>TILE_SHIFT. The wall bit comes from a 30-row x 40-column map.
- result = 1 only if both probes are in non-wall tiles and bounds pass; otherwise 0.
- Map content, fixed at elaboration (no runtime writes):
  - Walls: all of row 0, row 29, column 0 and column 39.
  - Open corridors: row 1, columns 1..38; column 1, rows 1..28; tiles (9,12),(9,13),(8,12),(8,13), the ghost home at pixel (200,146).
  - Remaining interior tiles come from the package maze constant.
- Direction change and position change in the same cycle: the new pair is evaluated together at the next edge; no stale mixing.
- Reset asserted mid-operation: result forced to 0 on that edge. Evaluation resumes the first edge after rst returns to 1.

Decomposition:
- Shared package maze_pkg holds:
  - direction encodings DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT;
  - TILE_SHIFT, MAZE_ROWS=30, MAZE_COLS=40;
  - the MAZE_MAP constant (30 x 40-bit rows, 1=wall).
- One sub-module, maze_tile_rom: combinational lookup of row/col -> wall bit, instantiated twice (one per probe).

Test Plan:
- Reset: rst=0 for 2 clkdiv edges with pos=(16,16), dir=00 -> result=0. Release rst; the next edge evaluates normally.
- Top wall: pos=(16,16), dir=00 -> ty=15 in row 0 -> result=0 one edge later.
- Open row: pos=(16,16), dir=11 -> probes (32,16),(32,31) are in row 1 -> result=1. Then sweep right; at pos_x=608, dir=11 -> col 39 wall -> result=0.
- Left underflow and wall: pos=(0,16), dir=10 -> result=0. pos=(16,16), dir=10 -> x=15 in col 0 -> result=0.
- Down corridor: pos=(16,16), dir=01 -> probes in column 1, row 2 -> result=1. At pos_y=448, dir=01 -> row 29 wall -> result=0.
- Bounds and timing: pos=(630,16), dir=11 -> right edge 646 >= 640 -> result=0. Change dir each cycle and confirm result tracks with exactly one-cycle latency.
